usb_rst_seq: RTL and testbench
==============================

Name: usb_rst_seq

Overview:
- Parametrised reset sequencer for the USB device core.
- Turns the single global reset into N staged per-domain resets, released in order: PHY/front-end first, then SIE, then endpoints.
- Re-runs the sequence on a software request.
- Detects USB bus reset (SE0 held ≥ 2.5 µs). While bus reset lasts, it holds a selectable subset of domains in reset, then re-sequences them.
- Sits between the top-level clock/reset inputs and the usb core sub-blocks.

Parameters:
- N_DOMAINS, 2: number of reset domains (≥1); bit 0 is released first.
- HOLD_CYC, 4: cycles all selected domains stay asserted before release starts (≥1).
- STAGE_DELAY, 16: cycles between successive domain releases (≥1).
- SE0_DET_CYC, 120: consecutive synchronised SE0 cycles that declare bus reset (2.5 µs at 48 MHz).
- SYNC_STAGES, 2: synchroniser depth on se0 (≥2).
- BUS_RST_MASK, all ones: bit i=1 means domain i is reset by a bus reset.

Ports:
- clk_48m  in  1  48 MHz system clock; the only clock.
- rst  in  1  asynchronous, active-high global reset.
- se0  in  1  raw line-state SE0 flag from the front-end; asynchronous.
- sw_rst_req  in  1  single-cycle software reset request.
- rst_out  out  N_DOMAINS  active-high per-domain resets, registered.
- bus_rst_det  out  1  one-cycle pulse when bus reset is recognised.
- bus_rst_active  out  1  high while in BUS_RST state.
- busy  out  1  high whenever any rst_out bit is or may be asserted (state ≠ RUN).

Behaviour:
- Reset: rst is asynchronous and active-high.
  - While rst=1: rst_out = all ones, bus_rst_det = 0, bus_rst_active = 0, busy = 1, state = HOLD, counters = 0, synchroniser = 0.
  - Asserting rst mid-operation forces these values immediately, with no clock needed.
- SE0 synchroniser and counter:
  - se0_s is se0 after SYNC_STAGES flops.
  - se0_cnt increments each cycle se0_s=1, saturates at SE0_DET_CYC, and clears on se0_s=0.
  - se0_cnt runs in all states.
  - SE0 shorter than SE0_DET_CYC synchronised cycles has no effect.
- bus_rst_det:
  - Registered; high for exactly one cycle, on the edge where se0_cnt goes SE0_DET_CYC-1 → SE0_DET_CYC.
  - Defaults: the pulse occurs 122 edges after the first edge that samples se0=1.
  - A saturated counter never re-pulses.
- FSM states: HOLD, RELEASE, RUN, BUS_RST.
  - HOLD:
    - Counts HOLD_CYC cycles.
    - rst_out bits already asserted stay asserted.
    - Then goes to RELEASE with the stage counter at 0.
  - RELEASE:
    - Stage counter increments each cycle.
    - rst_out[i] clears on the edge where counter = STAGE_DELAY·(i+1); bits already 0 stay 0.
    - On the edge that clears the slot of domain N_DOMAINS-1, goes to RUN and busy drops on that same edge.
  - RUN:
    - All rst_out = 0, busy = 0.
  - BUS_RST:
    - Entered from HOLD, RELEASE or RUN on the bus_rst_det edge.
    - On entry, rst_out |= BUS_RST_MASK; other bits keep their value.
    - bus_rst_active = 1.
    - Stays until se0_s=0, then goes to HOLD. bus_rst_active falls on that edge.
- sw_rst_req:
  - Accepted in HOLD, RELEASE and RUN.
  - Next edge: rst_out = all ones, and the FSM goes to HOLD with counters cleared. This restarts any sequence in progress.
  - Ignored in BUS_RST.
- Simultaneous sw_rst_req and bus_rst_det: bus_rst_det wins. rst_out becomes all ones OR BUS_RST_MASK (i.e. all ones), and the FSM enters BUS_RST.
- Widths:
  - Stage counter: clog2(STAGE_DELAY·N_DOMAINS+1) bits.
  - se0_cnt: clog2(SE0_DET_CYC+1) bits.
  - HOLD counter: clog2(HOLD_CYC+1) bits.
- All outputs are driven directly from flops; none is combinational.

Test Plan:
1. Power-up: rst high for 100 ns, then low.
   - rst_out stays 2'b11 for 4+16=20 edges after release.
   - rst_out[0] falls at edge 20 and rst_out[1] at edge 36; busy falls at edge 36.
2. sw_rst_req pulse in RUN.
   - Next edge: rst_out=2'b11 and busy=1.
   - rst_out[0] falls 20 edges later and rst_out[1] 36 edges later.
   - A second pulse at RELEASE cycle 10 restarts the 20/36 schedule from that pulse.
3. se0 high for 100 cycles, then low.
   - No bus_rst_det; rst_out stays 0; FSM stays in RUN.
4. se0 high for 10 µs, with BUS_RST_MASK=2'b10.
   - bus_rst_det pulses once at edge 122; rst_out becomes 2'b10; bus_rst_active=1 until 2 edges after se0 falls.
   - rst_out[0] stays 0 throughout; rst_out[1] clears 4+32 edges after BUS_RST exit.
5. sw_rst_req asserted on the same edge as the bus_rst_det pulse.
   - FSM enters BUS_RST.
   - Further sw_rst_req pulses during BUS_RST have no effect.
6. rst asserted mid-RELEASE.
   - rst_out goes to all ones immediately, without waiting for a clock edge.
   - bus_rst_active=0 and busy=1.
   - After deassert, the full 20/36 sequence repeats.

Source files
------------

// File: rtl/usb_rst_seq.sv
// Staged per-domain reset sequencer for the USB device core.
// Releases domains in index order and re-sequences after a software request or a USB bus reset.
module usb_rst_seq #(
  parameter int                   N_DOMAINS    = 2,
  parameter int                   HOLD_CYC     = 4,
  parameter int                   STAGE_DELAY  = 16,
  parameter int                   SE0_DET_CYC  = 120,
  parameter int                   SYNC_STAGES  = 2,
  parameter logic [N_DOMAINS-1:0] BUS_RST_MASK = '1
) (
  input  logic                 clk_48m,
  input  logic                 rst,
  input  logic                 se0,
  input  logic                 sw_rst_req,
  output logic [N_DOMAINS-1:0] rst_out,
  output logic                 bus_rst_det,
  output logic                 bus_rst_active,
  output logic                 busy
);

  localparam int STAGE_W = $clog2(STAGE_DELAY * N_DOMAINS + 1);
  localparam int SE0_W   = $clog2(SE0_DET_CYC + 1);
  localparam int HOLD_W  = $clog2(HOLD_CYC + 1);

  localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(STAGE_DELAY * N_DOMAINS);
  localparam logic [SE0_W-1:0]   SE0_SAT    = SE0_W'(SE0_DET_CYC);
  localparam logic [SE0_W-1:0]   SE0_LAST   = SE0_W'(SE0_DET_CYC - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYC - 1);

  typedef enum logic [1:0] {
    S_HOLD,
    S_RELEASE,
    S_RUN,
    S_BUS_RST
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SE0_W-1:0]       se0_cnt_q, se0_cnt_d;
  logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
  logic [STAGE_W-1:0]     stage_cnt_q, stage_cnt_d;
  logic [N_DOMAINS-1:0]   rst_out_q, rst_out_d;
  logic                   det_q, det_d;
  logic                   active_q, active_d;
  logic                   busy_q, busy_d;
  logic                   se0_s;

  assign se0_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_48m or posedge rst) begin
    if (rst) begin
      state_q     <= S_HOLD;
      sync_q      <= '0;
      se0_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      stage_cnt_q <= '0;
      rst_out_q   <= '1;
      det_q       <= 1'b0;
      active_q    <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      sync_q      <= {sync_q[SYNC_STAGES-2:0], se0};
      se0_cnt_q   <= se0_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      stage_cnt_q <= stage_cnt_d;
      rst_out_q   <= rst_out_d;
      det_q       <= det_d;
      active_q    <= active_d;
      busy_q      <= busy_d;
    end
  end

  // Bus reset wins over a simultaneous software request; BUS_RST ignores both.
  always_comb begin
    se0_cnt_d = se0_cnt_q;
    if (!se0_s) begin
      se0_cnt_d = '0;
    end else if (se0_cnt_q != SE0_SAT) begin
      se0_cnt_d = se0_cnt_q + SE0_W'(1);
    end
    det_d = se0_s && (se0_cnt_q == SE0_LAST);

    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    stage_cnt_d = stage_cnt_q;
    case (state_q)
      S_HOLD: begin
        if (det_d) begin
          state_d    = S_BUS_RST;
          hold_cnt_d = '0;
        end else if (sw_rst_req) begin
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d     = S_RELEASE;
          hold_cnt_d  = '0;
          stage_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      S_RELEASE: begin
        if (det_d) begin
          state_d     = S_BUS_RST;
          stage_cnt_d = '0;
        end else if (sw_rst_req) begin
          state_d     = S_HOLD;
          hold_cnt_d  = '0;
          stage_cnt_d = '0;
        end else begin
          stage_cnt_d = stage_cnt_q + STAGE_W'(1);
          if (stage_cnt_d == STAGE_LAST) begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (det_d) begin
          state_d = S_BUS_RST;
        end else if (sw_rst_req) begin
          state_d     = S_HOLD;
          hold_cnt_d  = '0;
          stage_cnt_d = '0;
        end
      end
      S_BUS_RST: begin
        if (!se0_s) begin
          state_d     = S_HOLD;
          hold_cnt_d  = '0;
          stage_cnt_d = '0;
        end
      end
      default: begin
        state_d     = S_HOLD;
        hold_cnt_d  = '0;
        stage_cnt_d = '0;
      end
    endcase
  end

  // Each domain's slot is the stage count at which its reset is dropped.
  always_comb begin
    rst_out_d = rst_out_q;
    if ((state_q != S_BUS_RST) && det_d) begin
      rst_out_d = (sw_rst_req ? {N_DOMAINS{1'b1}} : rst_out_q) | BUS_RST_MASK;
    end else if ((state_q != S_BUS_RST) && sw_rst_req) begin
      rst_out_d = {N_DOMAINS{1'b1}};
    end else if (state_q == S_RELEASE) begin
      for (int i = 0; i < N_DOMAINS; i++) begin
        if (stage_cnt_d == STAGE_W'(STAGE_DELAY * (i + 1))) begin
          rst_out_d[i] = 1'b0;
        end
      end
    end
    busy_d   = (state_d != S_RUN);
    active_d = (state_d == S_BUS_RST);
  end

  assign rst_out        = rst_out_q;
  assign bus_rst_det    = det_q;
  assign bus_rst_active = active_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_usb_rst_seq.sv
// Self-checking bench for usb_rst_seq: a timeline model (edges since each sequence start)
// checked every cycle, plus literal expectations at the key edges.
module tb_usb_rst_seq;

  localparam int         N     = 2;
  localparam int         HOLD  = 4;
  localparam int         STAGE = 16;
  localparam int         SE0C  = 120;
  localparam int         SYNC  = 2;
  localparam logic [1:0] MASK  = 2'b10;
  localparam int         LOG   = 4096;

  logic       clk_48m    = 1'b0;
  logic       rst        = 1'b1;
  logic       se0        = 1'b0;
  logic       sw_rst_req = 1'b0;
  logic [1:0] rst_out;
  logic       bus_rst_det;
  logic       bus_rst_active;
  logic       busy;

  usb_rst_seq #(
    .N_DOMAINS   (N),
    .HOLD_CYC    (HOLD),
    .STAGE_DELAY (STAGE),
    .SE0_DET_CYC (SE0C),
    .SYNC_STAGES (SYNC),
    .BUS_RST_MASK(MASK)
  ) dut (
    .clk_48m       (clk_48m),
    .rst           (rst),
    .se0           (se0),
    .sw_rst_req    (sw_rst_req),
    .rst_out       (rst_out),
    .bus_rst_det   (bus_rst_det),
    .bus_rst_active(bus_rst_active),
    .busy          (busy)
  );

  always #10 clk_48m = ~clk_48m;

  int checks    = 0;
  int failures  = 0;
  int detPulses = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic se0V, input logic swV);
    se0        = se0V;
    sw_rst_req = swV;
  endtask

  task automatic waitEdges(input int n);
    repeat (n) @(negedge clk_48m);
  endtask

  // Model: runLog holds the length of the raw se0 run ending at each edge; outputs follow
  // from how many edges have passed since the current sequence (or bus reset) began.
  int         runLog[0:LOG-1];
  int         edgeIdx;
  int         runNow;
  int         relK;
  bit         mInBus;
  bit         mSe0Prev;
  bit         mDet;
  int         mSeqStart;
  logic [1:0] mPend;
  logic [1:0] mHeld;
  logic [1:0] expRst;
  logic       expDet;
  logic       expAct;
  logic       expBusy;

  always @(posedge clk_48m or posedge rst) begin
    if (rst) begin
      edgeIdx   = 0;
      runLog[0] = 0;
      mInBus    = 1'b0;
      mSeqStart = 0;
      mPend     = 2'b11;
      mHeld     = 2'b00;
      expRst    = 2'b11;
      expDet    = 1'b0;
      expAct    = 1'b0;
      expBusy   = 1'b1;
    end else begin
      edgeIdx = edgeIdx + 1;
      runNow  = se0 ? ((edgeIdx == 1) ? 1 : runLog[(edgeIdx - 1) % LOG] + 1) : 0;
      runLog[edgeIdx % LOG] = runNow;
      mSe0Prev = (edgeIdx > SYNC) && (runLog[(edgeIdx - SYNC) % LOG] != 0);
      mDet     = (edgeIdx > SYNC) && (runLog[(edgeIdx - SYNC) % LOG] == SE0C);

      if (mInBus) begin
        if (!mSe0Prev) begin
          mInBus    = 1'b0;
          mSeqStart = edgeIdx;
          mPend     = mHeld;
        end
      end else if (mDet) begin
        mInBus = 1'b1;
        mHeld  = (sw_rst_req ? 2'b11 : expRst) | MASK;
      end else if (sw_rst_req) begin
        mSeqStart = edgeIdx;
        mPend     = 2'b11;
      end

      expDet = mDet;
      if (mInBus) begin
        expRst  = mHeld;
        expAct  = 1'b1;
        expBusy = 1'b1;
      end else begin
        relK = edgeIdx - mSeqStart;
        for (int i = 0; i < N; i++) begin
          expRst[i] = mPend[i] && (relK < HOLD + STAGE * (i + 1));
        end
        expAct  = 1'b0;
        expBusy = (relK < HOLD + STAGE * N);
      end
    end
  end

  always @(posedge clk_48m) begin
    #1;
    if (!rst) begin
      checkOutput("cyc_rst_out", rst_out, expRst);
      checkOutput("cyc_det", bus_rst_det, expDet);
      checkOutput("cyc_active", bus_rst_active, expAct);
      checkOutput("cyc_busy", busy, expBusy);
      if (bus_rst_det === 1'b1) detPulses++;
    end
  end

  task automatic checkSchedule(input string tag);
    waitEdges(19);
    checkOutput({tag, "_e19"}, rst_out, 2'b11);
    waitEdges(1);
    checkOutput({tag, "_e20"}, rst_out, 2'b10);
    waitEdges(15);
    checkOutput({tag, "_e35_busy"}, busy, 1'b1);
    waitEdges(1);
    checkOutput({tag, "_e36"}, rst_out, 2'b00);
    checkOutput({tag, "_e36_busy"}, busy, 1'b0);
  endtask

  task automatic pulseSw(input logic se0V);
    applyStimulus(se0V, 1'b1);
    waitEdges(1);
    applyStimulus(se0V, 1'b0);
  endtask

  initial begin
    int detBase;
    $display("[TB] start");

    // Power-up
    waitEdges(5);
    checkOutput("rst_rst_out", rst_out, 2'b11);
    checkOutput("rst_busy", busy, 1'b1);
    checkOutput("rst_active", bus_rst_active, 1'b0);
    checkOutput("rst_det", bus_rst_det, 1'b0);
    rst = 1'b0;
    checkSchedule("pwr");

    // Software request in RUN, then a restart in the middle of RELEASE
    waitEdges(3);
    pulseSw(1'b0);
    checkOutput("sw_rst_out", rst_out, 2'b11);
    checkOutput("sw_busy", busy, 1'b1);
    checkSchedule("sw1");
    waitEdges(2);
    pulseSw(1'b0);
    waitEdges(13);
    pulseSw(1'b0);
    checkOutput("sw2_rst_out", rst_out, 2'b11);
    checkSchedule("sw2");

    // Short SE0 is ignored
    detBase = detPulses;
    applyStimulus(1'b1, 1'b0);
    waitEdges(100);
    applyStimulus(1'b0, 1'b0);
    waitEdges(30);
    checkOutput("short_det_cnt", detPulses - detBase, 0);
    checkOutput("short_rst_out", rst_out, 2'b00);
    checkOutput("short_busy", busy, 1'b0);

    // Long SE0: bus reset of the masked domain only
    detBase = detPulses;
    applyStimulus(1'b1, 1'b0);
    waitEdges(121);
    checkOutput("bus_e121_det", bus_rst_det, 1'b0);
    waitEdges(1);
    checkOutput("bus_e122_det", bus_rst_det, 1'b1);
    checkOutput("bus_e122_rst", rst_out, 2'b10);
    checkOutput("bus_e122_act", bus_rst_active, 1'b1);
    waitEdges(1);
    checkOutput("bus_e123_det", bus_rst_det, 1'b0);
    waitEdges(357);
    applyStimulus(1'b0, 1'b0);
    waitEdges(2);
    checkOutput("bus_exit_e2_act", bus_rst_active, 1'b1);
    waitEdges(1);
    checkOutput("bus_exit_e3_act", bus_rst_active, 1'b0);
    checkOutput("bus_exit_rst", rst_out, 2'b10);
    waitEdges(35);
    checkOutput("bus_x35_rst", rst_out, 2'b10);
    waitEdges(1);
    checkOutput("bus_x36_rst", rst_out, 2'b00);
    checkOutput("bus_x36_busy", busy, 1'b0);
    checkOutput("bus_det_cnt", detPulses - detBase, 1);

    // Software request on the detection edge, then ignored during bus reset
    applyStimulus(1'b1, 1'b0);
    waitEdges(121);
    pulseSw(1'b1);
    checkOutput("coll_det", bus_rst_det, 1'b1);
    checkOutput("coll_rst", rst_out, 2'b11);
    checkOutput("coll_act", bus_rst_active, 1'b1);
    for (int j = 0; j < 3; j++) begin
      waitEdges(5);
      pulseSw(1'b1);
      checkOutput("coll_sw_rst", rst_out, 2'b11);
      checkOutput("coll_sw_act", bus_rst_active, 1'b1);
    end
    applyStimulus(1'b0, 1'b0);
    waitEdges(3);
    checkOutput("coll_exit_act", bus_rst_active, 1'b0);
    checkSchedule("coll");

    // Asynchronous reset in the middle of RELEASE
    waitEdges(2);
    pulseSw(1'b0);
    waitEdges(24);
    checkOutput("arst_pre_rst", rst_out, 2'b10);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("arst_rst_out", rst_out, 2'b11);
    checkOutput("arst_active", bus_rst_active, 1'b0);
    checkOutput("arst_busy", busy, 1'b1);
    checkOutput("arst_det", bus_rst_det, 1'b0);
    waitEdges(2);
    rst = 1'b0;
    checkSchedule("arst");

    waitEdges(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
